// File: rtl/iir_sched_pkg.sv
// Shared types and defaults for the IIR sample scheduler.
package iir_sched_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int NUM_CH_DEF     = 2;
    localparam int CNT_W          = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_ISSUE,
        ST_WAIT,
        ST_WRITE
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first requesting channel at or above rr_ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_CH = 2,
    parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  rr_ptr,
    output logic              gnt_valid,
    output logic [IDX_W-1:0]  gnt_idx
);

    logic [2*NUM_CH-1:0] req_dbl;
    logic [2*NUM_CH-1:0] req_rot;
    logic [IDX_W-1:0]    offset;
    logic [IDX_W:0]      sum;

    assign req_dbl = {req, req};
    assign req_rot = req_dbl >> rr_ptr;

    always_comb begin
        gnt_valid = 1'b0;
        offset    = '0;
        // Scan downward so the smallest offset from rr_ptr wins.
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                gnt_valid = 1'b1;
                offset    = IDX_W'(k);
            end
        end
        sum = {1'b0, rr_ptr} + {1'b0, offset};
        if (sum >= (IDX_W+1)'(NUM_CH)) begin
            sum = sum - (IDX_W+1)'(NUM_CH);
        end
        gnt_idx = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/iir_sched.sv
// Time-shares one IIR core across NUM_CH channels, keeping per-channel x[n-1]/y[n-1].
//
// state    | meaning
// IDLE     | pick next eligible channel round-robin
// READ     | pop channel FIFO, capture x[n]
// ISSUE    | present operands to core until core_ack
// WAIT     | wait for core_done, capture y[n]
// WRITE    | push y[n] once output FIFO has room, update history
module iir_sched
    import iir_sched_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int NUM_CH     = NUM_CH_DEF,
    parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         hist_clr,
    input  logic [NUM_CH-1:0]            in_empty,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_dout,
    output logic [NUM_CH-1:0]            in_rd_en,
    input  logic [NUM_CH-1:0]            out_full,
    output logic [NUM_CH-1:0]            out_wr_en,
    output logic [DATA_WIDTH-1:0]        out_din,
    output logic                         core_req,
    input  logic                         core_ack,
    output logic [DATA_WIDTH-1:0]        core_x,
    output logic [DATA_WIDTH-1:0]        core_x1,
    output logic [DATA_WIDTH-1:0]        core_y1,
    input  logic                         core_done,
    input  logic [DATA_WIDTH-1:0]        core_y,
    output logic                         busy,
    output logic [CH_W-1:0]              cur_ch,
    output logic [CNT_W-1:0]             sample_cnt
);

    state_e                state_q, state_d;
    logic [CH_W-1:0]       cur_ch_q, cur_ch_d;
    logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [DATA_WIDTH-1:0] x_cur_q;
    logic [DATA_WIDTH-1:0] y_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] x_hist_q [NUM_CH];
    logic [DATA_WIDTH-1:0] y_hist_q [NUM_CH];

    logic [NUM_CH-1:0]     eligible;
    logic                  gnt_valid;
    logic [CH_W-1:0]       gnt_idx;
    logic                  rd_fire;
    logic                  wr_fire;
    logic [CH_W-1:0]       ch_next;
    logic [NUM_CH-1:0]     ch_onehot;

    assign eligible = en ? (~in_empty & ~out_full) : '0;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .IDX_W  (CH_W)
    ) u_arb (
        .req       (eligible),
        .rr_ptr    (rr_ptr_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign ch_next   = (cur_ch_q == CH_W'(NUM_CH - 1)) ? '0 : cur_ch_q + CH_W'(1);
    assign ch_onehot = NUM_CH'(1) << cur_ch_q;

    always_comb begin
        state_d  = state_q;
        cur_ch_d = cur_ch_q;
        rr_ptr_d = rr_ptr_q;
        rd_fire  = 1'b0;
        wr_fire  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid) begin
                    cur_ch_d = gnt_idx;
                    state_d  = ST_READ;
                end
            end
            ST_READ: begin
                rd_fire = 1'b1;
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (core_ack) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (core_done) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (!out_full[cur_ch_q]) begin
                    wr_fire  = 1'b1;
                    rr_ptr_d = ch_next;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cur_ch_q <= '0;
            rr_ptr_q <= '0;
            x_cur_q  <= '0;
            y_q      <= '0;
            cnt_q    <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                x_hist_q[c] <= '0;
                y_hist_q[c] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cur_ch_q <= cur_ch_d;
            rr_ptr_q <= rr_ptr_d;
            if (rd_fire) begin
                x_cur_q <= in_dout[int'(cur_ch_q)*DATA_WIDTH +: DATA_WIDTH];
            end
            if (state_q == ST_WAIT && core_done) begin
                y_q <= core_y;
            end
            if (wr_fire) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            // A clear landing on the write cycle wins over the history update.
            if (hist_clr) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    x_hist_q[c] <= '0;
                    y_hist_q[c] <= '0;
                end
            end else if (wr_fire) begin
                x_hist_q[cur_ch_q] <= x_cur_q;
                y_hist_q[cur_ch_q] <= y_q;
            end
        end
    end

    assign in_rd_en   = rd_fire ? ch_onehot : '0;
    assign out_wr_en  = wr_fire ? ch_onehot : '0;
    assign out_din    = y_q;
    assign core_req   = (state_q == ST_ISSUE);
    assign core_x     = x_cur_q;
    assign core_x1    = x_hist_q[cur_ch_q];
    assign core_y1    = y_hist_q[cur_ch_q];
    assign busy       = (state_q != ST_IDLE);
    assign cur_ch     = cur_ch_q;
    assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_iir_sched.sv
// Scoreboard bench for iir_sched: FIFO and core models, directed sample vectors.
module tb_iir_sched;
    import iir_sched_pkg::*;

    localparam int DW  = 32;
    localparam int NCH = 2;
    localparam int LAT = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              hist_clr = 1'b0;
    logic [NCH-1:0]    in_empty;
    logic [NCH*DW-1:0] in_dout;
    logic [NCH-1:0]    in_rd_en;
    logic [NCH-1:0]    out_full;
    logic [NCH-1:0]    out_wr_en;
    logic [DW-1:0]     out_din;
    logic              core_req;
    logic              core_ack;
    logic [DW-1:0]     core_x, core_x1, core_y1;
    logic              core_done;
    logic [DW-1:0]     core_y;
    logic              busy;
    logic [0:0]        cur_ch;
    logic [15:0]       sample_cnt;

    always #5 clk = ~clk;

    iir_sched #(.DATA_WIDTH(DW), .NUM_CH(NCH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .hist_clr   (hist_clr),
        .in_empty   (in_empty),
        .in_dout    (in_dout),
        .in_rd_en   (in_rd_en),
        .out_full   (out_full),
        .out_wr_en  (out_wr_en),
        .out_din    (out_din),
        .core_req   (core_req),
        .core_ack   (core_ack),
        .core_x     (core_x),
        .core_x1    (core_x1),
        .core_y1    (core_y1),
        .core_done  (core_done),
        .core_y     (core_y),
        .busy       (busy),
        .cur_ch     (cur_ch),
        .sample_cnt (sample_cnt)
    );

    typedef struct packed {
        logic [DW-1:0] x;
        logic [DW-1:0] x1;
        logic [DW-1:0] y1;
    } op_t;

    op_t           op_q   [NCH][$];
    logic [DW-1:0] out_q  [NCH][$];
    logic [DW-1:0] in_fifo[NCH][$];
    logic [DW-1:0] mx1[NCH];
    logic [DW-1:0] my1[NCH];
    int            grant_log[$];
    int            errors = 0;
    int            checks = 0;
    int            writes = 0;
    int            rd_count = 0;
    int            req_cycles = 0;
    int            ack_delay = 0;
    logic [DW-1:0] last_out = '0;
    logic [DW-1:0] last_x1 = '0;
    logic [DW-1:0] last_y1 = '0;
    logic [NCH-1:0] pop_pend = '0;
    logic          prev_req = 1'b0;
    logic [3*DW-1:0] prev_ops = '0;
    op_t           mon_op;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] core_fn(input logic [DW-1:0] x, input logic [DW-1:0] x1,
                                              input logic [DW-1:0] y1);
        logic signed [DW-1:0] r;
        r = ($signed(x) >>> 1) + ($signed(x1) >>> 2) + ($signed(y1) >>> 2);
        return r;
    endfunction

    task automatic drive_fifo();
        for (int c = 0; c < NCH; c++) begin
            in_empty[c] = (in_fifo[c].size() == 0);
            in_dout[c*DW +: DW] = (in_fifo[c].size() != 0) ? in_fifo[c][0] : '0;
        end
    endtask

    task automatic push(input int c, input logic [DW-1:0] x);
        op_t o;
        logic [DW-1:0] y;
        o.x  = x;
        o.x1 = mx1[c];
        o.y1 = my1[c];
        y = core_fn(x, mx1[c], my1[c]);
        op_q[c].push_back(o);
        out_q[c].push_back(y);
        mx1[c] = x;
        my1[c] = y;
        in_fifo[c].push_back(x);
        drive_fifo();
    endtask

    task automatic clear_model();
        for (int c = 0; c < NCH; c++) begin
            op_q[c].delete();
            out_q[c].delete();
            in_fifo[c].delete();
            mx1[c] = '0;
            my1[c] = '0;
        end
        grant_log.delete();
        writes = 0;
        rd_count = 0;
        req_cycles = 0;
        drive_fifo();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        en = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_done(input int target, input string name);
        int n;
        n = 0;
        while (!(writes >= target && !busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(name, (n < 3000), 1'b1);
    endtask

    // FIFO model: pops seen at the falling edge retire just after the next rising edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int c = 0; c < NCH; c++) begin
                if (pop_pend[c] && in_fifo[c].size() != 0) begin
                    void'(in_fifo[c].pop_front());
                end
            end
            pop_pend = '0;
            drive_fifo();
        end
    end

    // Core model: ack after ack_delay waiting cycles, result LAT cycles later.
    initial begin
        int phase;
        int w;
        int lat;
        logic [DW-1:0] cx, cx1, cy1;
        phase = 0; w = 0; lat = 0;
        cx = '0; cx1 = '0; cy1 = '0;
        core_ack = 1'b0;
        core_done = 1'b0;
        core_y = '0;
        forever begin
            @(posedge clk);
            #1;
            core_ack = 1'b0;
            core_done = 1'b0;
            if (!rst_n) begin
                phase = 0;
                w = 0;
            end else if (phase == 0) begin
                if (core_req) begin
                    if (w < ack_delay) begin
                        w++;
                    end else begin
                        core_ack = 1'b1;
                        cx = core_x; cx1 = core_x1; cy1 = core_y1;
                        w = 0; lat = 0; phase = 1;
                    end
                end
            end else begin
                lat++;
                if (lat == LAT) begin
                    core_done = 1'b1;
                    core_y = core_fn(cx, cx1, cy1);
                    phase = 0;
                end
            end
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_rd_en != '0) begin
                check("rd_onehot", $onehot(in_rd_en), 1'b1);
                check("rd_no_req", core_req, 1'b0);
                pop_pend = in_rd_en;
                rd_count++;
            end
            if (core_req) begin
                req_cycles++;
                if (prev_req) begin
                    check("op_stable", {core_x, core_x1, core_y1}, prev_ops);
                end
                if (core_ack) begin
                    grant_log.push_back(int'(cur_ch));
                    last_x1 = core_x1;
                    last_y1 = core_y1;
                    if (op_q[cur_ch].size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_issue: ch %0d", cur_ch);
                    end else begin
                        mon_op = op_q[cur_ch].pop_front();
                        check("core_x", core_x, mon_op.x);
                        check("core_x1", core_x1, mon_op.x1);
                        check("core_y1", core_y1, mon_op.y1);
                    end
                end
            end
            prev_req = core_req;
            prev_ops = {core_x, core_x1, core_y1};
            if (out_wr_en != '0) begin
                check("wr_ch", out_wr_en, NCH'(1) << cur_ch);
                if (out_q[cur_ch].size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: ch %0d data %0h", cur_ch, out_din);
                end else begin
                    check("out_din", out_din, out_q[cur_ch].pop_front());
                end
                writes++;
                last_out = out_din;
            end
        end else begin
            prev_req = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        out_full = '0;
        for (int c = 0; c < NCH; c++) begin
            mx1[c] = '0;
            my1[c] = '0;
        end
        drive_fifo();
        do_reset();

        // Reset state
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_rd", in_rd_en, '0);
        check("rst_wr", out_wr_en, '0);
        check("rst_req", core_req, 1'b0);
        check("rst_cnt", sample_cnt, '0);
        check("rst_ch", cur_ch, '0);
        check("rst_din", out_din, '0);
        check("rst_x", core_x, '0);

        // Single sample on ch0 then history reuse
        en = 1'b1;
        push(0, 32'h100);
        wait_done(1, "t1_done");
        check("t1_out", last_out, 32'h80);
        check("t1_pops", rd_count, 1);
        check("t1_cnt", sample_cnt, 16'd1);
        push(0, 32'h200);
        wait_done(2, "t1b_done");
        check("t1b_x1", last_x1, 32'h100);
        check("t1b_y1", last_y1, 32'h80);
        check("t1b_out", last_out, 32'h160);

        // Fairness with both channels loaded
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push(0, 32'h10 * (i + 1));
            push(1, 32'h1000 * (i + 1));
        end
        @(negedge clk);
        en = 1'b1;
        wait_done(8, "t2_done");
        check("t2_cnt", sample_cnt, 16'd8);
        check("t2_ngrant", grant_log.size(), 8);
        for (int i = 0; i < grant_log.size(); i++) begin
            check("t2_order", grant_log[i], i % 2);
        end

        // Output backpressure on ch1
        do_reset();
        out_full = 2'b10;
        en = 1'b1;
        push(1, 32'h500);
        push(1, 32'h600);
        push(0, 32'h700);
        push(0, 32'h800);
        wait_done(2, "t3_done0");
        repeat (5) @(negedge clk);
        check("t3_ngrant", grant_log.size(), 2);
        for (int i = 0; i < grant_log.size(); i++) begin
            check("t3_only_ch0", grant_log[i], 0);
        end
        check("t3_ch1_left", in_fifo[1].size(), 2);
        check("t3_idle", busy, 1'b0);
        out_full = 2'b00;
        wait_done(4, "t3_done1");
        check("t3_resume_a", grant_log[2], 1);
        check("t3_resume_b", grant_log[3], 1);

        // Core handshake stall
        do_reset();
        ack_delay = 10;
        en = 1'b1;
        push(0, 32'h300);
        wait_done(1, "t4_done");
        check("t4_req_cycles", req_cycles, 11);
        check("t4_pops", rd_count, 1);
        ack_delay = 0;

        // Asynchronous reset while waiting on the core
        do_reset();
        en = 1'b1;
        push(0, 32'h400);
        n = 0;
        while (grant_log.size() == 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t5_issue_seen", (n < 100), 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_busy", busy, 1'b0);
        check("t5_req", core_req, 1'b0);
        check("t5_wr", out_wr_en, '0);
        check("t5_rd", in_rd_en, '0);
        check("t5_cnt", sample_cnt, '0);
        check("t5_din", out_din, '0);
        check("t5_x", core_x, '0);
        clear_model();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("t5_no_write", writes, 0);
        check("t5_cnt_after", sample_cnt, '0);

        // History clear coinciding with the write cycle
        do_reset();
        en = 1'b1;
        push(0, 32'h100);
        n = 0;
        while (!out_wr_en[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t6_write_seen", (n < 100), 1'b1);
        hist_clr = 1'b1;
        @(posedge clk);
        #1;
        hist_clr = 1'b0;
        wait_done(1, "t6_done");
        mx1[0] = '0;
        my1[0] = '0;
        push(0, 32'h200);
        wait_done(2, "t6b_done");
        check("t6_x1", last_x1, '0);
        check("t6_y1", last_y1, '0);
        check("t6_out", last_out, 32'h100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/iir_sched.md
IIR_SCHED -- requirements
Module: iir_sched

Interface
REQ-001 The block SHALL have these parameters: DATA_WIDTH, default 32, sample width; NUM_CH, default 2, channel count (L/R deemphasis).
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, the single clock.
- rst_n, in, 1, reset; asynchronous, active-low.
- en, in, 1, scheduling enable.
- hist_clr, in, 1, single-cycle pulse that zeroes all channel history.
- in_empty, in, NUM_CH, per-channel input FIFO empty.
- in_dout, in, NUM_CH*DATA_WIDTH, per-channel FWFT FIFO data; channel c is at bits [c*DATA_WIDTH +: DATA_WIDTH].
- in_rd_en, out, NUM_CH, per-channel FIFO pop.
- out_full, in, NUM_CH, per-channel output FIFO full.
- out_wr_en, out, NUM_CH, per-channel output FIFO push.
- out_din, out, DATA_WIDTH, shared output write data.
- core_req, out, 1, operand valid to the shared IIR core.
- core_ack, in, 1, core accepts operands.
- core_x, out, DATA_WIDTH, current sample x[n].
- core_x1, out, DATA_WIDTH, stored x[n-1] of the active channel.
- core_y1, out, DATA_WIDTH, stored y[n-1] of the active channel.
- core_done, in, 1, result valid.
- core_y, in, DATA_WIDTH, result y[n].
- busy, out, 1, high when not in IDLE.
- cur_ch, out, $clog2(NUM_CH), active channel.
- sample_cnt, out, 16, count of completed samples.

Function
REQ-003 FSM states SHALL be IDLE, READ, ISSUE, WAIT, WRITE.
REQ-004 In IDLE, a channel SHALL be eligible when en=1, in_empty[c]=0 and out_full[c]=0.
REQ-005 In IDLE, grant SHALL be round-robin: the first eligible channel searching upward from rr_ptr, wrapping modulo NUM_CH.
REQ-006 On grant, the block SHALL latch cur_ch and go to READ; with no eligible channel it SHALL stay in IDLE.
REQ-007 In READ, the block SHALL drive in_rd_en[cur_ch]=1 for exactly one cycle, latch in_dout slice into x_cur, and go to ISSUE.
REQ-008 In ISSUE, core_req SHALL be 1 with core_x=x_cur, core_x1=x_hist[cur_ch], core_y1=y_hist[cur_ch], operands stable until core_ack.
REQ-009 The block SHALL leave ISSUE for WAIT in the cycle core_ack=1.
REQ-010 In WAIT, the block SHALL latch core_y on core_done=1 and go to WRITE; there is no timeout.
REQ-011 In WRITE, if out_full[cur_ch]=0, the block SHALL pulse out_wr_en[cur_ch] one cycle with out_din=latched y.
REQ-012 In that same WRITE cycle the block SHALL set x_hist[cur_ch]=x_cur, y_hist[cur_ch]=y, rr_ptr=(cur_ch+1) mod NUM_CH, increment sample_cnt (wraps at 16 bits), and go to IDLE.
REQ-013 If out_full[cur_ch]=1 in WRITE, the block SHALL hold in WRITE with all outputs stable.
REQ-014 At most one in_rd_en bit and one out_wr_en bit SHALL be high per cycle, and all of in_rd_en, out_wr_en and core_req SHALL be 0 outside READ, WRITE and ISSUE respectively.
REQ-015 Only one core operation SHALL be outstanding; minimum per-sample latency is IDLE to IDLE = 4 cycles + core latency.
REQ-016 Deasserting en mid-operation SHALL NOT abort the operation; the current sample completes, then the block stays in IDLE.
REQ-017 hist_clr SHALL zero every x_hist/y_hist entry.
REQ-018 If hist_clr coincides with a WRITE, the clear SHALL take priority; the written sample is still output.
REQ-019 Arithmetic SHALL be none; all data paths SHALL be pass-through DATA_WIDTH signed values.

Reset
REQ-020 rst_n=0 SHALL asynchronously force IDLE, rr_ptr=0, cur_ch=0, x_hist=y_hist=0, x_cur=0, latched y=0, sample_cnt=0, and all outputs to 0.
REQ-021 Reset mid-operation SHALL drop any in-flight sample; the core sees core_req fall and no out_wr_en is issued.

Structure
REQ-022 Package iir_sched_pkg SHALL hold the state enum, the DATA_WIDTH/NUM_CH defaults and the 16-bit count width.
REQ-023 Grant logic SHALL be one sub-module, rr_arbiter (inputs: req vector, rr_ptr; outputs: gnt_valid, gnt_idx).

Verification
REQ-024 Single sample: ch0 in_dout=0x00000100, core returns 0x00000080 after 3 cycles -> one in_rd_en[0], out_wr_en[0] with out_din=0x80, and ch0 history (0x100, 0x80) presented on the next ch0 issue.
REQ-025 Fairness: both FIFOs non-empty with 4 samples each -> grants alternate 0,1,0,1,..., sample_cnt=8, and per-channel histories are never mixed.
REQ-026 Backpressure: out_full[1]=1 while ch1 has data -> ch1 is never granted and ch0 is still serviced; releasing out_full[1] resumes ch1 next IDLE.
REQ-027 Handshake stall: core_ack held low 10 cycles -> core_req and operands stay constant, with no FIFO pop until completion.
REQ-028 Async reset asserted in WAIT -> all outputs 0 immediately, no out_wr_en, and sample_cnt=0.
REQ-029 hist_clr coincident with WRITE -> sample written, next issue sees core_x1=core_y1=0.
